// File: rtl/window_cmd_arbiter.sv
// window_cmd_arbiter: conditions the driver, passenger and remote window
// commands (sync, debounce, stuck and conflict masking), arbitrates them by
// fixed priority and turns the winner into single-cycle start/stop pulses
// for the window motor controller. INM feedback tracks the motion.
module window_cmd_arbiter #(
    parameter logic [15:0] DEBOUNCE    = 16'd20,
    parameter logic [15:0] ACK_TIMEOUT = 16'd50,
    parameter logic [15:0] HOLDOFF     = 16'd100,
    parameter logic [15:0] STUCK_LIMIT = 16'd30000
) (
    input  logic       SYSCLK,
    input  logic       RST_N,
    input  logic       drv_up,
    input  logic       drv_down,
    input  logic       psg_up,
    input  logic       psg_down,
    input  logic       rmt_close,
    input  logic       child_lock,
    input  logic [1:0] INM,
    output logic       s_c_up,
    output logic       s_c_down,
    output logic [1:0] grant,
    output logic       busy,
    output logic       fault_stuck
);
    // Valid/ready does not apply here: every command is a one-cycle pulse
    // that the motor controller must accept, and INM is the only feedback.

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_ACK, ST_ACTIVE, ST_STOP_WAIT, ST_HOLDOFF
    } state_t;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_DRV  = 2'b01;
    localparam logic [1:0] G_RMT  = 2'b10;
    localparam logic [1:0] G_PSG  = 2'b11;

    // Raw input bit order: 0 drv_up, 1 drv_down, 2 psg_up, 3 psg_down, 4 rmt_close
    logic [4:0]  raw, cond, rise, stuck;
    logic [4:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [4:0]  deb_q, deb_d, deb_prev_q, deb_prev_d, evt_q, evt_d;
    logic [15:0] deb_cnt_q [5];
    logic [15:0] deb_cnt_d [5];
    logic [15:0] stuck_cnt_q [5];
    logic [15:0] stuck_cnt_d [5];
    logic        drv_inv_q, drv_inv_d, psg_inv_q, psg_inv_d;
    logic        drv_block, psg_block, rmt_block;

    state_t      state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic        dir_q, dir_d;              // 0 = up/close, 1 = down/open
    logic [1:0]  grant_q, grant_d;
    logic        s_c_up_q, s_c_up_d, s_c_down_q, s_c_down_d;
    logic        busy_q, busy_d, fault_stuck_q, fault_stuck_d;

    logic        ev_drv, ev_rmt, ev_psg, any_ev, stop_req, inm_match;
    logic        ack_done, hold_done;
    logic [1:0]  win_grant;
    logic        win_dir;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign raw = {rmt_close, psg_down, psg_up, drv_down, drv_up};

    // Input conditioning: synchronize, debounce, stuck counting, conflict masks, press events
    always_comb begin
        sync1_d    = raw;
        sync2_d    = sync1_q;
        cond       = sync2_q & ~{1'b0, child_lock, child_lock, 2'b00};
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < 5; i++) begin
            deb_cnt_d[i] = 16'd0;
            if (cond[i] != deb_q[i]) begin
                if (deb_cnt_q[i] >= DEBOUNCE - 16'd1) deb_d[i] = cond[i];
                else deb_cnt_d[i] = sat_inc(deb_cnt_q[i]);
            end
            stuck_cnt_d[i] = deb_q[i] ? sat_inc(stuck_cnt_q[i]) : 16'd0;
            stuck[i]       = (stuck_cnt_q[i] >= STUCK_LIMIT);
        end
        // A source with both directions held stays invalid until both are released
        drv_inv_d = (deb_q[0] & deb_q[1]) | (drv_inv_q & (deb_q[0] | deb_q[1]));
        psg_inv_d = (deb_q[2] & deb_q[3]) | (psg_inv_q & (deb_q[2] | deb_q[3]));
        drv_block = drv_inv_d | stuck[0] | stuck[1];
        psg_block = psg_inv_d | stuck[2] | stuck[3];
        rmt_block = stuck[4];
        rise      = deb_q & ~deb_prev_q;
        evt_d     = rise & ~{rmt_block, psg_block, psg_block, drv_block, drv_block};
        fault_stuck_d = |stuck;
    end

    // Conditioning registers
    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '0; sync2_q <= '0; deb_q <= '0; deb_prev_q <= '0; evt_q <= '0;
            drv_inv_q <= 1'b0; psg_inv_q <= 1'b0; fault_stuck_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i]   <= 16'd0;
                stuck_cnt_q[i] <= 16'd0;
            end
        end else begin
            sync1_q <= sync1_d; sync2_q <= sync2_d; deb_q <= deb_d;
            deb_prev_q <= deb_prev_d; evt_q <= evt_d;
            drv_inv_q <= drv_inv_d; psg_inv_q <= psg_inv_d; fault_stuck_q <= fault_stuck_d;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i]   <= deb_cnt_d[i];
                stuck_cnt_q[i] <= stuck_cnt_d[i];
            end
        end
    end

    // Arbitration and next-state decision
    always_comb begin
        ev_drv    = evt_q[0] | evt_q[1];
        ev_rmt    = evt_q[4];
        ev_psg    = evt_q[2] | evt_q[3];
        any_ev    = ev_drv | ev_rmt | ev_psg;
        win_grant = G_NONE;
        win_dir   = 1'b0;
        if (ev_drv) begin
            win_grant = G_DRV;
            win_dir   = ~evt_q[0];
        end else if (ev_rmt) begin
            win_grant = G_RMT;
            win_dir   = 1'b0;
        end else if (ev_psg) begin
            win_grant = G_PSG;
            win_dir   = ~evt_q[2];
        end
        // Stop is accepted from the owner or anything that outranks it
        case (grant_q)
            G_DRV:   stop_req = ev_drv;
            G_RMT:   stop_req = ev_drv | ev_rmt;
            G_PSG:   stop_req = any_ev;
            default: stop_req = 1'b0;
        endcase
        inm_match = dir_q ? (INM == 2'b10) : (INM == 2'b01);
        ack_done  = (tmr_q >= ACK_TIMEOUT - 16'd1);
        hold_done = (tmr_q >= HOLDOFF - 16'd1);
        state_d   = state_q;
        case (state_q)
            ST_IDLE:      if (any_ev) state_d = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (inm_match) state_d = ST_ACTIVE;
                          else if (ack_done) state_d = ST_HOLDOFF;
            ST_ACTIVE:    if (INM == 2'b00) state_d = ST_HOLDOFF;
                          else if (stop_req) state_d = ST_STOP_WAIT;
            ST_STOP_WAIT: if ((INM == 2'b00) || ack_done) state_d = ST_HOLDOFF;
            ST_HOLDOFF:   if (hold_done) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output decode: pulses, grant, direction and timer derived from the transition
    always_comb begin
        s_c_up_d   = 1'b0;
        s_c_down_d = 1'b0;
        grant_d    = grant_q;
        dir_d      = dir_q;
        busy_d     = (state_q != ST_IDLE);
        tmr_d      = (state_d != state_q) ? 16'd0 : sat_inc(tmr_q);
        if (state_q == ST_IDLE && state_d == ST_WAIT_ACK) begin
            grant_d    = win_grant;
            dir_d      = win_dir;
            s_c_up_d   = ~win_dir;
            s_c_down_d = win_dir;
        end
        if (state_q == ST_ACTIVE && state_d == ST_STOP_WAIT) begin
            s_c_up_d   = ~dir_q;
            s_c_down_d = dir_q;
        end
        if (state_d == ST_HOLDOFF) grant_d = G_NONE;
    end

    // State and registered outputs
    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE; tmr_q <= 16'd0; dir_q <= 1'b0; grant_q <= G_NONE;
            s_c_up_q <= 1'b0; s_c_down_q <= 1'b0; busy_q <= 1'b0;
        end else begin
            state_q <= state_d; tmr_q <= tmr_d; dir_q <= dir_d; grant_q <= grant_d;
            s_c_up_q <= s_c_up_d; s_c_down_q <= s_c_down_d; busy_q <= busy_d;
        end
    end

    assign s_c_up      = s_c_up_q;
    assign s_c_down    = s_c_down_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign fault_stuck = fault_stuck_q;
endmodule

// File: tb/tb_window_cmd_arbiter.sv
// Bench for window_cmd_arbiter: table of single-press vectors from idle plus
// hand-written sequences for ACTIVE stop, ack timeout, holdoff, stuck and reset.
module tb_window_cmd_arbiter;
    logic       SYSCLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       drv_up = 1'b0, drv_down = 1'b0, psg_up = 1'b0, psg_down = 1'b0;
    logic       rmt_close = 1'b0, child_lock = 1'b0;
    logic [1:0] INM = 2'b00;
    logic       s_c_up, s_c_down, busy, fault_stuck;
    logic [1:0] grant;

    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q[$];          // expected pulses, {up, down}
    logic prev_pulse = 1'b0;

    localparam logic [1:0] P_UP = 2'b10;
    localparam logic [1:0] P_DN = 2'b01;

    window_cmd_arbiter dut (
        .SYSCLK(SYSCLK), .RST_N(RST_N), .drv_up(drv_up), .drv_down(drv_down),
        .psg_up(psg_up), .psg_down(psg_down), .rmt_close(rmt_close),
        .child_lock(child_lock), .INM(INM), .s_c_up(s_c_up), .s_c_down(s_c_down),
        .grant(grant), .busy(busy), .fault_stuck(fault_stuck)
    );

    // clock / reset
    always #5 SYSCLK = ~SYSCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every pulse must match the next expected entry and be one cycle wide
    always @(negedge SYSCLK) begin
        if (s_c_up || s_c_down) begin
            check("pulse_width_prev", prev_pulse, 0);
            if (exp_q.size() == 0) check("unexpected_pulse", {s_c_up, s_c_down}, 0);
            else check("pulse_kind", {s_c_up, s_c_down}, exp_q.pop_front());
        end
        prev_pulse = s_c_up | s_c_down;
    end

    // driver tasks
    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic set_raw(input logic [4:0] r);
        {rmt_close, psg_down, psg_up, drv_down, drv_up} = r;
    endtask

    task automatic wait_pulse(input int max_ticks, output int n, output logic found,
                              output logic got_up);
        n = 0; found = 1'b0; got_up = 1'b0;
        while (n < max_ticks && !found) begin
            tick();
            n++;
            if (s_c_up || s_c_down) begin
                found = 1'b1;
                got_up = s_c_up;
            end
        end
    endtask

    typedef struct {
        logic [4:0] raw;       // {rmt, psg_dn, psg_up, drv_dn, drv_up}
        logic       cl;
        logic       exp_pulse;
        logic       exp_up;
        logic [1:0] exp_grant;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int n;
        logic found, got_up;

        vecs[0]  = '{5'b00001, 1'b0, 1'b1, 1'b1, 2'b01};  // drv_up
        vecs[1]  = '{5'b00010, 1'b0, 1'b1, 1'b0, 2'b01};  // drv_down
        vecs[2]  = '{5'b10000, 1'b0, 1'b1, 1'b1, 2'b10};  // remote
        vecs[3]  = '{5'b00100, 1'b0, 1'b1, 1'b1, 2'b11};  // psg_up
        vecs[4]  = '{5'b01000, 1'b0, 1'b1, 1'b0, 2'b11};  // psg_down
        vecs[5]  = '{5'b00100, 1'b1, 1'b0, 1'b0, 2'b00};  // psg_up, child lock
        vecs[6]  = '{5'b00011, 1'b0, 1'b0, 1'b0, 2'b00};  // drv both -> invalid
        vecs[7]  = '{5'b11000, 1'b0, 1'b1, 1'b1, 2'b10};  // rmt beats psg_down
        vecs[8]  = '{5'b10110, 1'b0, 1'b1, 1'b0, 2'b01};  // drv_down beats rmt, psg
        vecs[9]  = '{5'b01100, 1'b0, 1'b0, 1'b0, 2'b00};  // psg both -> invalid
        vecs[10] = '{5'b01000, 1'b1, 1'b0, 1'b0, 2'b00};  // psg_down, child lock

        // reset state
        repeat (3) tick();
        check("rst_s_c_up", s_c_up, 0);
        check("rst_s_c_down", s_c_down, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault_stuck, 0);
        RST_N = 1'b1;
        repeat (2) tick();

        // table: one press from idle, INM held 00 so each start times out
        for (int v = 0; v < 11; v++) begin
            child_lock = vecs[v].cl;
            if (vecs[v].exp_pulse) exp_q.push_back(vecs[v].exp_up ? P_UP : P_DN);
            set_raw(vecs[v].raw);
            wait_pulse(40, n, found, got_up);
            check($sformatf("vec%0d_found", v), found, vecs[v].exp_pulse);
            if (vecs[v].exp_pulse) begin
                check($sformatf("vec%0d_latency", v), n, 24);
                check($sformatf("vec%0d_up", v), got_up, vecs[v].exp_up);
            end
            check($sformatf("vec%0d_grant", v), grant, vecs[v].exp_grant);
            set_raw(5'b0);
            repeat (200) tick();
            child_lock = 1'b0;
            check($sformatf("vec%0d_idle", v), busy, 0);
        end

        // A: driver up, ack, motion complete, holdoff length
        exp_q.push_back(P_UP);
        drv_up = 1'b1;
        wait_pulse(40, n, found, got_up);
        check("a_latency", n, 24);
        check("a_grant", grant, 1);
        INM = 2'b01;
        tick();
        drv_up = 1'b0;
        check("a_busy", busy, 1);
        repeat (10) tick();
        INM = 2'b00;
        tick();
        check("a_grant_clear", grant, 0);
        repeat (100) tick();
        check("a_busy_h100", busy, 1);
        tick();
        check("a_busy_h101", busy, 0);

        // B: driver stop in ACTIVE, then press during holdoff is discarded
        exp_q.push_back(P_UP);
        drv_up = 1'b1;
        wait_pulse(40, n, found, got_up);
        check("b_start_latency", n, 24);
        INM = 2'b01;
        drv_up = 1'b0;
        repeat (30) tick();
        check("b_active_grant", grant, 1);
        exp_q.push_back(P_UP);
        drv_down = 1'b1;
        wait_pulse(40, n, found, got_up);
        check("b_stop_latency", n, 24);
        check("b_stop_up", got_up, 1);
        check("b_stopwait_grant", grant, 1);
        INM = 2'b00;
        tick();
        check("b_grant_clear", grant, 0);
        drv_down = 1'b0;
        repeat (30) tick();
        drv_up = 1'b1;
        wait_pulse(40, n, found, got_up);
        check("b_holdoff_nopulse", found, 0);
        repeat (60) tick();
        check("b_idle", busy, 0);
        drv_up = 1'b0;
        repeat (30) tick();

        // C: remote wins over passenger; passenger press in ACTIVE ignored; remote stops
        exp_q.push_back(P_UP);
        rmt_close = 1'b1;
        psg_down = 1'b1;
        wait_pulse(40, n, found, got_up);
        check("c_latency", n, 24);
        check("c_grant", grant, 2);
        INM = 2'b01;
        rmt_close = 1'b0;
        psg_down = 1'b0;
        repeat (30) tick();
        psg_down = 1'b1;
        wait_pulse(40, n, found, got_up);
        check("c_low_prio_ignored", found, 0);
        check("c_grant_kept", grant, 2);
        psg_down = 1'b0;
        repeat (30) tick();
        exp_q.push_back(P_UP);
        rmt_close = 1'b1;
        wait_pulse(40, n, found, got_up);
        check("c_stop_latency", n, 24);
        INM = 2'b00;
        rmt_close = 1'b0;
        repeat (150) tick();
        check("c_idle", busy, 0);

        // D: start with no ack -> holdoff exactly ACK_TIMEOUT cycles later
        exp_q.push_back(P_DN);
        drv_down = 1'b1;
        wait_pulse(40, n, found, got_up);
        check("d_latency", n, 24);
        check("d_down", got_up, 0);
        drv_down = 1'b0;
        repeat (49) tick();
        check("d_grant_t49", grant, 1);
        tick();
        check("d_grant_t50", grant, 0);
        repeat (100) tick();
        check("d_busy_h100", busy, 1);
        tick();
        check("d_busy_h101", busy, 0);

        // E: stuck driver input, mask, release, then reset mid-ACTIVE
        exp_q.push_back(P_UP);
        drv_up = 1'b1;
        wait_pulse(40, n, found, got_up);
        check("e_first_latency", n, 24);
        repeat (30022 - 24) tick();
        check("e_fault_30022", fault_stuck, 0);
        tick();
        check("e_fault_30023", fault_stuck, 1);
        drv_down = 1'b1;
        wait_pulse(40, n, found, got_up);
        check("e_masked_nopulse", found, 0);
        drv_down = 1'b0;
        repeat (30) tick();
        check("e_fault_held", fault_stuck, 1);
        drv_up = 1'b0;
        repeat (30) tick();
        check("e_fault_clear", fault_stuck, 0);
        exp_q.push_back(P_UP);
        drv_up = 1'b1;
        wait_pulse(40, n, found, got_up);
        check("e_repress_latency", n, 24);
        check("e_repress_grant", grant, 1);
        INM = 2'b01;
        repeat (2) tick();
        check("e_busy_active", busy, 1);
        RST_N = 1'b0;
        set_raw(5'b0);
        INM = 2'b00;
        #1;
        check("e_rst_s_c_up", s_c_up, 0);
        check("e_rst_s_c_down", s_c_down, 0);
        check("e_rst_grant", grant, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_fault", fault_stuck, 0);
        repeat (3) tick();
        RST_N = 1'b1;
        repeat (60) tick();
        check("e_post_rst_idle", busy, 0);

        // final report
        check("pending_pulses", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/window_cmd_arbiter.md
Name: window_cmd_arbiter

Overview:
- Front-end sequencer for the anti-pinch window motor controller.
- Debounces three command sources: driver switch, passenger switch and remote comfort-close. Arbitrates between them by fixed priority.
- Converts the winning request into the single-cycle start/stop pulses the motor controller expects on its s_c_up/s_c_down inputs.
- Watches the motor drive code (INM) to track motion, detect missing starts and enforce a hold-off between commands.

Parameters:
- DEBOUNCE, 20, cycles a raw input must be stable before its debounced value changes (1 ms clock).
- ACK_TIMEOUT, 50, cycles allowed after a start pulse for INM to become non-zero.
- HOLDOFF, 100, cycles of enforced idle after motion ends or is aborted.
- STUCK_LIMIT, 16'd30000, cycles a debounced input may stay high before its source is masked.

Ports:
- SYSCLK  in  1  system clock, 1 kHz
- RST_N  in  1  asynchronous active-low reset
- drv_up  in  1  raw driver switch, up/close
- drv_down  in  1  raw driver switch, down/open
- psg_up  in  1  raw passenger switch, up
- psg_down  in  1  raw passenger switch, down
- rmt_close  in  1  raw remote comfort-close request
- child_lock  in  1  level; 1 masks both passenger inputs
- INM  in  2  motor drive code from controller; [0]=up drive, [1]=down drive
- s_c_up  out  1  single-cycle up start/stop pulse to motor controller
- s_c_down  out  1  single-cycle down start/stop pulse to motor controller
- grant  out  2  current owner: 00 none, 01 driver, 10 remote, 11 passenger
- busy  out  1  high in any state other than IDLE
- fault_stuck  out  1  high while any source is masked for a stuck input

Behaviour:
- Reset and timing:
  - Asynchronous active-low reset on RST_N; single clock SYSCLK.
  - Reset forces state IDLE and zeroes every output, synchronizer, debounced value, counter and mask. This applies mid-operation too; no stop pulse is emitted on reset.
- Input conditioning, per raw input:
  - 2-FF synchronizer.
  - Debounce counter: reloads to 0 while the synced value equals the debounced value. When it reaches DEBOUNCE-1 the debounced value flips.
  - A press event is a 0->1 transition of the debounced value.
- Source validity:
  - child_lock=1 masks psg_up and psg_down before edge detection.
  - Up and down debounced high together on the same source marks that source invalid; no event from it until both are low.
  - rmt_close maps to the up direction only.
- Stuck detection: a per-input counter increments while its debounced value is 1. At STUCK_LIMIT the source is masked and fault_stuck=1. The mask clears when that input debounces to 0.
- Arbitration: same-cycle events resolve by priority driver > remote > passenger.
- State machine, one-hot or binary at implementer's choice:
  - IDLE:
    - On the highest-priority press event, latch its source into grant and its direction into dir.
    - Assert the matching s_c_up or s_c_down for exactly one cycle, then go to WAIT_ACK.
  - WAIT_ACK:
    - Counter runs from 0.
    - INM matches dir (up->01, down->10): go to ACTIVE.
    - Counter reaches ACK_TIMEOUT: go to HOLDOFF, grant=00.
    - Press events are ignored here.
  - ACTIVE:
    - INM==00 (motion complete or pinch stop): go to HOLDOFF, grant=00.
    - Press event from the granted source or any higher-priority source, either direction: emit a one-cycle pulse on the line matching the current dir (stop command), then go to STOP_WAIT.
    - Press events from lower-priority sources are ignored.
  - STOP_WAIT:
    - INM==00: go to HOLDOFF.
    - Otherwise, after ACK_TIMEOUT cycles: go to HOLDOFF with no further pulse.
    - grant cleared on exit.
  - HOLDOFF:
    - Count HOLDOFF cycles, then go to IDLE.
    - Events during HOLDOFF are discarded, not queued.
- Pulse rules:
  - s_c_up and s_c_down are never high together.
  - Each pulse is one cycle; back-to-back pulses are impossible (at least 2 cycles apart by construction).
  - Outputs are registered.
- Widths: all counters are 16-bit, saturating; no wrap-around.
- busy is registered, and equals (state != IDLE) one cycle after the state change.

Test Plan:
- Reset, then drv_up held high 25 cycles -> s_c_up high exactly 1 cycle, 22 cycles after the synced edge; grant=01. Drive INM=01 -> ACTIVE; INM=00 -> grant=00, busy low after 100 cycles.
- psg_down and rmt_close rise the same cycle with child_lock=0 -> only s_c_up pulses, grant=10. A later psg_down press during ACTIVE -> no pulse.
- During driver-owned ACTIVE up move, drv_down pressed -> one s_c_up (stop) pulse. INM=00 -> HOLDOFF; a drv_up press during HOLDOFF -> no pulse.
- Start pulse issued, INM held 00 -> HOLDOFF entered 50 cycles later, no further pulses.
- drv_up held 30000+ cycles -> fault_stuck=1 and drv events ignored. Release -> fault_stuck=0, next press pulses normally. Also: RST_N low mid-ACTIVE -> all outputs 0 immediately.
- child_lock=1 with psg_up press -> no pulse. drv_up and drv_down together -> no pulse.
